// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank with one synchronous write port,
// two registered read ports and a hardware clear sequencer.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (zeroes the bank, aborts a sweep)
//   we      write enable (honoured only while idle)
//   waddr   write address (addresses >= DEPTH are dropped)
//   wdata   write data
//   raddr0  read address, port 0
//   rdata0  registered read data, port 0 (write-first)
//   raddr1  read address, port 1
//   rdata1  registered read data, port 1 (write-first)
//   clr     start a clear sweep (sampled only while idle)
//   busy    high while the clear sweep runs (equals state == CLEAR)
//
// Handshake: there is no valid/ready pair; a read address presented before
// an edge yields data after that edge, and busy=1 means writes and clr are
// ignored for that edge.

module reg_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr0,
   output logic [WIDTH-1:0] rdata0,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata1,
   input  logic             clr,
   output logic             busy
);

   localparam logic [0:0]    IDLE  = 1'b0;
   localparam logic [0:0]    CLEAR = 1'b1;
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

   logic [0:0]       state;
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_en;
   logic             clr_en;
   logic [WIDTH-1:0] rd0_next;
   logic [WIDTH-1:0] rd1_next;

   // busy comes straight from the state flop, so no input reaches an output
   // combinationally.
   assign busy   = (state == CLEAR);
   assign clr_en = (state == CLEAR);
   assign wr_en  = (state == IDLE) && we && (32'(waddr) < DEPTH);

   // Value an entry will hold after the coming edge; gives the read ports
   // their write-first behaviour. Out-of-range addresses match no entry and
   // therefore read as zero.
   always_comb begin
      rd0_next = '0;
      rd1_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr0 == AW'(i)) begin
            if (clr_en && idx == AW'(i))        rd0_next = '0;
            else if (wr_en && waddr == AW'(i))  rd0_next = wdata;
            else                                rd0_next = mem[i];
         end
         if (raddr1 == AW'(i)) begin
            if (clr_en && idx == AW'(i))        rd1_next = '0;
            else if (wr_en && waddr == AW'(i))  rd1_next = wdata;
            else                                rd1_next = mem[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         rdata0 <= '0;
         rdata1 <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         rdata0 <= rd0_next;
         rdata1 <= rd1_next;

         // Sweep clear and host write are mutually exclusive by state.
         for (int i = 0; i < DEPTH; i++) begin
            if (clr_en && idx == AW'(i))       mem[i] <= '0;
            else if (wr_en && waddr == AW'(i)) mem[i] <= wdata;
         end

         if (state == IDLE) begin
            if (clr) begin
               state <= CLEAR;
               idx   <= '0;
            end
         end else begin
            // clr is ignored here: the sweep is never restarted or queued.
            if (idx == LAST) begin
               state <= IDLE;
               idx   <= '0;
            end else begin
               idx <= idx + AW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT with DEPTH=8
   logic       rst_n8 = 1'b0;
   logic       we8 = 1'b0, clr8 = 1'b0;
   logic [2:0] waddr8 = '0, raddr0_8 = '0, raddr1_8 = '0;
   logic [7:0] wdata8 = '0;
   logic [7:0] rdata0_8, rdata1_8;
   logic       busy8;

   // DUT with DEPTH=6 (non-power-of-two, AW=3)
   logic       rst_n6 = 1'b0;
   logic       we6 = 1'b0, clr6 = 1'b0;
   logic [2:0] waddr6 = '0, raddr0_6 = '0, raddr1_6 = '0;
   logic [7:0] wdata6 = '0;
   logic [7:0] rdata0_6, rdata1_6;
   logic       busy6;

   reg_bank #(.WIDTH(8), .DEPTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n8), .we(we8), .waddr(waddr8), .wdata(wdata8),
      .raddr0(raddr0_8), .rdata0(rdata0_8), .raddr1(raddr1_8), .rdata1(rdata1_8),
      .clr(clr8), .busy(busy8)
   );

   reg_bank #(.WIDTH(8), .DEPTH(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n6), .we(we6), .waddr(waddr6), .wdata(wdata6),
      .raddr0(raddr0_6), .rdata0(rdata0_6), .raddr1(raddr1_6), .rdata1(rdata1_6),
      .clr(clr6), .busy(busy6)
   );

   // Expected entry: {chk[2:0] (busy,rdata0,rdata1), busy, rdata0, rdata1}
   localparam int EW = 20;
   logic [EW-1:0] exp8_q[$];
   logic [EW-1:0] exp6_q[$];
   int checks = 0;
   int errors = 0;
   string phase = "reset";

   function automatic logic [EW-1:0] mk(input logic [2:0] chk, input logic b,
                                        input logic [7:0] e0, input logic [7:0] e1);
      return {chk, b, e0, e1};
   endfunction

   task automatic compare(input string dut, input logic [EW-1:0] e,
                          input logic b, input logic [7:0] r0, input logic [7:0] r1);
      if (e[19]) begin
         checks++;
         if (b !== e[16]) begin
            errors++;
            $display("FAIL %s %s busy got=%b exp=%b t=%0t", dut, phase, b, e[16], $time);
         end
      end
      if (e[18]) begin
         checks++;
         if (r0 !== e[15:8]) begin
            errors++;
            $display("FAIL %s %s rdata0 got=%h exp=%h t=%0t", dut, phase, r0, e[15:8], $time);
         end
      end
      if (e[17]) begin
         checks++;
         if (r1 !== e[7:0]) begin
            errors++;
            $display("FAIL %s %s rdata1 got=%h exp=%h t=%0t", dut, phase, r1, e[7:0], $time);
         end
      end
   endtask

   // Monitor: one expectation per cycle per DUT, compared after the edge.
   always @(posedge clk) begin
      #2;
      if (exp8_q.size() > 0) compare("dut8", exp8_q.pop_front(), busy8, rdata0_8, rdata1_8);
      if (exp6_q.size() > 0) compare("dut6", exp6_q.pop_front(), busy6, rdata0_6, rdata1_6);
   end

   // One cycle of stimulus on DUT d (8 or 6); the other DUT is held idle and
   // gets an unchecked entry.
   task automatic cyc(input int d, input logic w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] a0, input logic [2:0] a1, input logic c,
                      input logic [2:0] chk, input logic eb,
                      input logic [7:0] e0, input logic [7:0] e1);
      @(negedge clk);
      if (d == 8) begin
         we8 = w; waddr8 = wa; wdata8 = wd; raddr0_8 = a0; raddr1_8 = a1; clr8 = c;
         we6 = 1'b0; clr6 = 1'b0;
         exp8_q.push_back(mk(chk, eb, e0, e1));
         exp6_q.push_back('0);
      end else begin
         we6 = w; waddr6 = wa; wdata6 = wd; raddr0_6 = a0; raddr1_6 = a1; clr6 = c;
         we8 = 1'b0; clr8 = 1'b0;
         exp6_q.push_back(mk(chk, eb, e0, e1));
         exp8_q.push_back('0);
      end
   endtask

   // Idle cycle on both DUTs, checking all outputs are zero.
   task automatic idle_both();
      @(negedge clk);
      we8 = 1'b0; clr8 = 1'b0; raddr0_8 = '0; raddr1_8 = '0;
      we6 = 1'b0; clr6 = 1'b0; raddr0_6 = '0; raddr1_6 = '0;
      exp8_q.push_back(mk(3'b111, 1'b0, 8'h00, 8'h00));
      exp6_q.push_back(mk(3'b111, 1'b0, 8'h00, 8'h00));
   endtask

   initial begin
      // Reset held for 2 cycles, then released; everything stays zero.
      phase = "reset";
      idle_both();
      idle_both();
      rst_n8 = 1'b1;
      rst_n6 = 1'b1;
      idle_both();
      idle_both();
      idle_both();

      // Write and readback on consecutive edges (write-first on port 0/1).
      phase = "write";
      cyc(8, 1, 3'd0, 8'h01, 3'd0, 3'd0, 0, 3'b111, 0, 8'h01, 8'h01);
      cyc(8, 1, 3'd1, 8'h02, 3'd0, 3'd1, 0, 3'b111, 0, 8'h01, 8'h02);
      cyc(8, 1, 3'd7, 8'h99, 3'd0, 3'd7, 0, 3'b111, 0, 8'h01, 8'h99);
      cyc(8, 0, 3'd0, 8'h00, 3'd0, 3'd7, 0, 3'b111, 0, 8'h01, 8'h99);
      cyc(8, 0, 3'd0, 8'h00, 3'd1, 3'd0, 0, 3'b111, 0, 8'h02, 8'h01);

      // Write-first, both ports on the written address.
      phase = "wfirst";
      cyc(8, 1, 3'd3, 8'hA5, 3'd3, 3'd3, 0, 3'b111, 0, 8'hA5, 8'hA5);
      cyc(8, 0, 3'd0, 8'h00, 3'd3, 3'd2, 0, 3'b111, 0, 8'hA5, 8'h00);

      // Fill with FF.
      phase = "fill";
      for (int i = 0; i < 8; i++)
         cyc(8, 1, 3'(i), 8'hFF, 3'(i), 3'd0, 0, 3'b111, 0, 8'hFF, 8'hFF);

      // clr edge: the write to entry 5 sampled with clr is still performed.
      phase = "clr_edge";
      cyc(8, 1, 3'd5, 8'h3C, 3'd5, 3'd2, 1, 3'b111, 1, 8'h3C, 8'hFF);

      // Sweep edges 1..8 clear entries 0..7; writes ignored; clr mid-sweep ignored.
      phase = "sweep";
      for (int j = 1; j <= 8; j++)
         cyc(8, 1, 3'd2, 8'h55, 3'd7, 3'd2, (j == 4), 3'b111, (j < 8),
             (j == 8) ? 8'h00 : 8'hFF, (j >= 3) ? 8'h00 : 8'hFF);

      phase = "post_sweep";
      cyc(8, 0, 3'd0, 8'h00, 3'd2, 3'd5, 0, 3'b111, 0, 8'h00, 8'h00);
      cyc(8, 1, 3'd2, 8'h55, 3'd2, 3'd7, 0, 3'b111, 0, 8'h55, 8'h00);
      cyc(8, 0, 3'd0, 8'h00, 3'd2, 3'd0, 0, 3'b111, 0, 8'h55, 8'h00);

      // DEPTH=6: fill, start sweep, reset at idx=3.
      phase = "d6_fill";
      for (int i = 0; i < 6; i++)
         cyc(6, 1, 3'(i), 8'(8'h10 + i), 3'(i), 3'd0, 0, 3'b111, 0, 8'(8'h10 + i), 8'h10);
      phase = "d6_sweep";
      cyc(6, 0, 3'd0, 8'h00, 3'd0, 3'd5, 1, 3'b111, 1, 8'h10, 8'h15);
      for (int j = 1; j <= 3; j++)
         cyc(6, 0, 3'd0, 8'h00, 3'd0, 3'd5, 0, 3'b111, 1, 8'h00, 8'h15);

      phase = "d6_reset";
      @(negedge clk);
      rst_n6 = 1'b0;
      #1;
      checks++;
      if (busy6 !== 1'b0) begin
         errors++;
         $display("FAIL dut6 d6_reset busy_async got=%b exp=0", busy6);
      end
      exp6_q.push_back(mk(3'b111, 0, 8'h00, 8'h00));
      exp8_q.push_back('0);
      cyc(6, 0, 3'd0, 8'h00, 3'd3, 3'd4, 0, 3'b111, 0, 8'h00, 8'h00);
      rst_n6 = 1'b1;
      cyc(6, 0, 3'd0, 8'h00, 3'd5, 3'd4, 0, 3'b111, 0, 8'h00, 8'h00);

      // Out-of-range addresses: writes dropped, reads return 0.
      phase = "d6_oor";
      cyc(6, 1, 3'd7, 8'hAA, 3'd7, 3'd0, 0, 3'b111, 0, 8'h00, 8'h00);
      cyc(6, 1, 3'd6, 8'hBB, 3'd6, 3'd7, 0, 3'b111, 0, 8'h00, 8'h00);
      cyc(6, 0, 3'd0, 8'h00, 3'd0, 3'd1, 0, 3'b111, 0, 8'h00, 8'h00);
      cyc(6, 0, 3'd0, 8'h00, 3'd2, 3'd3, 0, 3'b111, 0, 8'h00, 8'h00);
      cyc(6, 0, 3'd0, 8'h00, 3'd4, 3'd5, 0, 3'b111, 0, 8'h00, 8'h00);
      cyc(6, 1, 3'd4, 8'h44, 3'd4, 3'd6, 0, 3'b111, 0, 8'h44, 8'h00);

      // Drain the scoreboard (bounded).
      phase = "drain";
      @(negedge clk);
      we6 = 1'b0;
      for (int k = 0; k < 10 && (exp8_q.size() > 0 || exp6_q.size() > 0); k++)
         @(negedge clk);
      checks++;
      if (exp8_q.size() != 0 || exp6_q.size() != 0) begin
         errors++;
         $display("FAIL drain queue got=%0d/%0d exp=0/0", exp8_q.size(), exp6_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of DEPTH registers, each WIDTH bits, with one synchronous write port, two registered read ports, and a hardware clear sequencer that zeroes the bank one entry per cycle. It generalises the single 8-bit D register into the storage block used by datapath exercises, such as accumulators and small register-file CPUs. Read data follows write-first semantics, so a same-cycle write is visible on the read ports at the next edge.

## Interface
- WIDTH, 8: bits per register (≥1)
- DEPTH, 8: number of registers (≥2; need not be a power of two)
- AW, $clog2(DEPTH): address width (derived; not to be overridden)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr0  in  AW  read address, port 0
- rdata0  out  WIDTH  registered read data, port 0
- raddr1  in  AW  read address, port 1
- rdata1  out  WIDTH  registered read data, port 1
- clr  in  1  start clear sweep (sampled only in IDLE)
- busy  out  1  high while the clear sweep runs

## Operation
- Storage: mem[0..DEPTH-1], WIDTH bits each.
- Reset (rst_n=0, asynchronous): all mem entries = 0, rdata0 = rdata1 = 0, busy = 0, state = IDLE, sweep index = 0. Asserting reset during a sweep aborts it.
- Write: in IDLE, when we=1 and waddr<DEPTH, mem[waddr] ← wdata at the edge. If waddr≥DEPTH, the write is dropped.
- While busy=1, we is ignored and no write occurs.
- Read: at each edge, rdataN ← the value mem[raddrN] holds after that edge (write-first). If raddrN≥DEPTH, rdataN ← 0. Both ports are independent, and equal addresses are legal.
- State machine:
  - IDLE: if clr=1 at an edge, go to CLEAR with idx=0 and busy=1. A write sampled at the same edge as clr is still performed, and the sweep later wipes it.
  - CLEAR: at each edge, mem[idx] ← 0 and idx ← idx+1. At the edge where idx=DEPTH-1, clear the last entry, go to IDLE, set busy=0, and reset idx to 0.
  - clr is ignored while in CLEAR; no restart and no queuing.
- Reads are allowed during CLEAR. An entry cleared at an edge reads 0 from that edge on. Entries not yet reached keep their old value.

## Timing
- Write-to-read latency: a write at edge k appears on rdataN after edge k when raddrN=waddr at edge k.
- Read latency: 1 cycle; the address is presented before edge k and the data is valid after edge k.
- busy rises after the edge that samples clr and stays high for exactly DEPTH cycles.
- The first write accepted after a clear is the one at the edge following busy falling.
- Sweep order is ascending, from index 0 to DEPTH-1.
- No combinational path from any input to any output.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, release, and leave raddr0=raddr1=0. Required: rdata0=rdata1=0 and busy=0 throughout.
- Write and readback (WIDTH=8, DEPTH=8): write 8'h01→0, 8'h02→1, 8'h99→7 on consecutive edges, then read 0 and 7 on the two ports. Required: rdata0=8'h01 and rdata1=8'h99 one cycle after the address is applied.
- Write-first and dual-port: set we=1, waddr=3, wdata=8'hA5, raddr0=raddr1=3 on the same edge. Required: rdata0=rdata1=8'hA5 after that edge.
- Clear sweep: fill all 8 entries with 8'hFF, pulse clr for 1 cycle, and keep raddr0=7 with we=1, waddr=2, wdata=8'h55 during the sweep. Required:
  - busy is high for exactly 8 cycles.
  - rdata0 stays 8'hFF until the 8th edge, then becomes 8'h00.
  - mem[2]=0 after the sweep (the write was ignored).
  - A second clr pulse mid-sweep does not extend busy.
- Reset mid-sweep and out-of-range (DEPTH=6, AW=3): start a sweep, then drop rst_n at idx=3. Required: busy=0 immediately and all entries read 0. Then write to address 7 and read address 7. Required: rdata=0, and entries 0..5 are unchanged.
